// File: rtl/trig_burst_gen.sv
// Burst pulse generator: each accepted trigger emits BURST_LEN pulses of
// PULSE_W cycles, spaced PERIOD cycles apart, then a one-cycle done strobe.
// Reports busy, dropped triggers (missed) and a saturating completed-burst count.
module trig_burst_gen #(
  parameter int BURST_LEN = 4,
  parameter int PERIOD    = 3,
  parameter int PULSE_W   = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trigger,
  input  logic             abort,
  input  logic             cnt_clr,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             missed,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam int GAP_W   = PERIOD - PULSE_W;
  localparam int TMR_MAX = (PULSE_W > GAP_W) ? (PULSE_W - 1) : (GAP_W - 1);
  localparam int TMR_W   = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;
  localparam int IDX_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [TMR_W-1:0] PW_LAST  = TMR_W'(PULSE_W - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             inc;
  logic             missed_d;

  // State, phase timer, pulse index and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      idx_q     <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      missed    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      idx_q     <= idx_d;
      // Outputs are decoded from the next state so they line up with it
      pulse_out <= (state_d == PULSE);
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);
      missed    <= missed_d;
    end
  end

  // Next-state logic: phase timing, abort handling and dropped-trigger detect
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    idx_d    = idx_q;
    inc      = 1'b0;
    missed_d = (state_q != IDLE) && trigger && !abort;
    case (state_q)
      IDLE: begin
        if (trigger && !abort) begin
          state_d = PULSE;
          tmr_d   = '0;
          idx_d   = '0;
        end
      end
      PULSE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tmr_q == PW_LAST) begin
          tmr_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
            inc     = 1'b1;
          end else begin
            state_d = GAP;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tmr_q == GAP_LAST) begin
          tmr_d   = '0;
          idx_d   = idx_q + 1'b1;
          state_d = PULSE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Completed-burst counter: counts on entry to DONE, saturates, clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt <= '0;
    end else if (cnt_clr) begin
      evt_cnt <= '0;
    end else if (inc && (evt_cnt != '1)) begin
      evt_cnt <= evt_cnt + 1'b1;
    end
  end

endmodule
